simon_game_ctrl: RTL and testbench

Game sequencer for the Simon Says datapath. It drives the seed generator, RNG, colour segments, flash timer, LED driver and checker through the FSM signal bundle. It takes player start and press strobes and advances rounds, speed, win and lose. It is the single owner of every FSM command in the bundle.

---
 rtl/simon_pkg.sv | 30 +++
 rtl/simon_game_ctrl_if.sv | 31 +++
 rtl/round_index_ctr.sv | 46 ++++
 rtl/simon_game_ctrl.sv | 124 ++++++++++++
 tb/tb_simon_game_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says game sequencer.
package simon_pkg;

    localparam int         ROUND_W   = 6;
    localparam logic [2:0] SPEED_MAX = 3'd7;

    typedef enum logic [3:0] {
        CLEAR,
        IDLE,
        START,
        LOAD,
        SHOW_ON,
        SHOW_OFF,
        INPUT,
        WIN,
        LOSE
    } game_state_t;

    // Speed code for a given round, saturating at SPEED_MAX (7-bit intermediate).
    function automatic logic [2:0] speed_for_round(
        input logic [6:0] rnd,
        input logic [6:0] init,
        input logic [6:0] step
    );
        logic [6:0] sum;
        sum = init + (rnd / step);
        return (sum > {4'd0, SPEED_MAX}) ? SPEED_MAX : sum[2:0];
    endfunction

endpackage

// File: rtl/simon_game_ctrl_if.sv
// Command/status bundle between the game sequencer and the Simon datapath blocks.
interface simon_game_ctrl_if;

    logic                         btn_go;
    logic                         btn_press;
    logic                         result;
    logic                         pulse;
    logic                         start;
    logic                         load_colour;
    logic                         load_speed;
    logic                         rst_seedgen;
    logic                         flash_clk;
    logic [simon_pkg::ROUND_W-1:0] check_round;
    logic [2:0]                   speed;
    logic [simon_pkg::ROUND_W-1:0] round;
    logic                         win;
    logic                         lose;

    modport fsm (
        input  btn_go, btn_press, result, pulse,
        output start, load_colour, load_speed, rst_seedgen, flash_clk,
               check_round, speed, round, win, lose
    );

    modport dp (
        output btn_go, btn_press, result, pulse,
        input  start, load_colour, load_speed, rst_seedgen, flash_clk,
               check_round, speed, round, win, lose
    );

endinterface

// File: rtl/round_index_ctr.sv
// Round and sequence-index counters plus the registered speed code for the game sequencer.
module round_index_ctr
    import simon_pkg::*;
#(
    parameter int SPEED_STEP = 4,
    parameter int INIT_SPEED = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               idx_clr,
    input  logic               idx_inc,
    input  logic               rnd_inc,
    output logic [ROUND_W-1:0] round,
    output logic [ROUND_W-1:0] index,
    output logic [2:0]         speed
);

    logic [6:0] round_next;
    logic [2:0] speed_next;

    assign round_next = {1'b0, round} + 7'd1;
    assign speed_next = speed_for_round(round_next, 7'(INIT_SPEED), 7'(SPEED_STEP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round <= '0;
            index <= '0;
            speed <= 3'(INIT_SPEED);
        end else if (clr) begin
            round <= '0;
            index <= '0;
            speed <= 3'(INIT_SPEED);
        end else if (rnd_inc) begin
            // index restarts with the round so LOAD already presents colour 0
            round <= round_next[ROUND_W-1:0];
            index <= '0;
            speed <= speed_next;
        end else if (idx_clr) begin
            index <= '0;
        end else if (idx_inc) begin
            index <= index + 6'd1;
        end
    end

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon Says game sequencer: Moore FSM owning every command in the datapath bundle.
//   state    | meaning
//   CLEAR    | seed generator held in reset, counters cleared
//   IDLE     | seed generator free-runs, waiting for btn_go
//   START    | RNG sequence start strobe
//   LOAD     | latch speed and first colour of the round
//   SHOW_ON  | colour at check_round flashing
//   SHOW_OFF | gap between flashes
//   INPUT    | player entering the sequence
//   WIN      | all rounds completed, wait for btn_go
//   LOSE     | wrong entry, wait for btn_go
module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int MAX_ROUND  = 32,
    parameter int SPEED_STEP = 4,
    parameter int INIT_SPEED = 0
) (
    input logic            clk,
    input logic            rst_n,
    simon_game_ctrl_if.fsm bus
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUND - 1);

    game_state_t        state, state_nxt;
    logic               reload, reload_nxt;
    logic               ctr_clr, idx_clr, idx_inc, rnd_inc;
    logic [ROUND_W-1:0] round, index;
    logic [2:0]         speed;

    round_index_ctr #(
        .SPEED_STEP(SPEED_STEP),
        .INIT_SPEED(INIT_SPEED)
    ) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (ctr_clr),
        .idx_clr(idx_clr),
        .idx_inc(idx_inc),
        .rnd_inc(rnd_inc),
        .round  (round),
        .index  (index),
        .speed  (speed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLEAR;
            reload <= 1'b0;
        end else begin
            state  <= state_nxt;
            reload <= reload_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        reload_nxt = 1'b0;
        ctr_clr    = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        rnd_inc    = 1'b0;
        case (state)
            CLEAR: begin
                ctr_clr   = 1'b1;
                state_nxt = IDLE;
            end
            IDLE:  if (bus.btn_go) state_nxt = START;
            START: state_nxt = LOAD;
            LOAD: begin
                idx_clr   = 1'b1;
                state_nxt = SHOW_ON;
            end
            SHOW_ON: if (bus.pulse) state_nxt = SHOW_OFF;
            SHOW_OFF: begin
                if (bus.pulse) begin
                    if (index == round) begin
                        idx_clr   = 1'b1;
                        state_nxt = INPUT;
                    end else begin
                        idx_inc    = 1'b1;
                        reload_nxt = 1'b1;
                        state_nxt  = SHOW_ON;
                    end
                end
            end
            INPUT: begin
                if (bus.btn_press) begin
                    if (!bus.result) begin
                        state_nxt = LOSE;
                    end else if (index < round) begin
                        idx_inc = 1'b1;
                    end else if (round == LAST_ROUND) begin
                        state_nxt = WIN;
                    end else begin
                        rnd_inc   = 1'b1;
                        state_nxt = LOAD;
                    end
                end
            end
            WIN, LOSE: begin
                // clear on the way in so CLEAR already shows round 0
                if (bus.btn_go) begin
                    ctr_clr   = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign bus.start       = (state == START);
    assign bus.load_speed  = (state == LOAD);
    assign bus.load_colour = (state == LOAD) || ((state == SHOW_ON) && reload);
    assign bus.rst_seedgen = (state == CLEAR);
    assign bus.flash_clk   = (state == SHOW_ON);
    assign bus.win         = (state == WIN);
    assign bus.lose        = (state == LOSE);
    assign bus.check_round = index;
    assign bus.round       = round;
    assign bus.speed       = speed;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Self-checking bench for simon_game_ctrl: directed game scenarios plus random strobes vs a phase-level model.
module tb_simon_game_ctrl;

    localparam int MAX_ROUND  = 6;
    localparam int SPEED_STEP = 2;
    localparam int INIT_SPEED = 6;

    localparam int P_CLEAR = 0, P_IDLE = 1, P_START = 2, P_LOAD = 3, P_SHOW_ON = 4,
                   P_SHOW_OFF = 5, P_INPUT = 6, P_WIN = 7, P_LOSE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    int m_phase, m_prev, m_round, m_idx;

    simon_game_ctrl_if bus ();

    simon_game_ctrl #(
        .MAX_ROUND (MAX_ROUND),
        .SPEED_STEP(SPEED_STEP),
        .INIT_SPEED(INIT_SPEED)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = P_CLEAR;
        m_prev  = P_CLEAR;
        m_round = 0;
        m_idx   = 0;
    endtask

    task automatic model_step(input bit go, input bit press, input bit res, input bit pls);
        int nxt;
        nxt = m_phase;
        case (m_phase)
            P_CLEAR:  begin m_round = 0; m_idx = 0; nxt = P_IDLE; end
            P_IDLE:   if (go) nxt = P_START;
            P_START:  nxt = P_LOAD;
            P_LOAD:   begin m_idx = 0; nxt = P_SHOW_ON; end
            P_SHOW_ON: if (pls) nxt = P_SHOW_OFF;
            P_SHOW_OFF: if (pls) begin
                if (m_idx == m_round) begin m_idx = 0; nxt = P_INPUT; end
                else begin m_idx++; nxt = P_SHOW_ON; end
            end
            P_INPUT: if (press) begin
                if (!res)                          nxt = P_LOSE;
                else if (m_idx < m_round)          m_idx++;
                else if (m_round == MAX_ROUND - 1) nxt = P_WIN;
                else begin m_round++; m_idx = 0; nxt = P_LOAD; end
            end
            P_WIN, P_LOSE: if (go) begin m_round = 0; m_idx = 0; nxt = P_CLEAR; end
            default: nxt = P_CLEAR;
        endcase
        m_prev  = m_phase;
        m_phase = nxt;
    endtask

    function automatic logic [21:0] model_vec();
        int sp;
        sp = INIT_SPEED + m_round / SPEED_STEP;
        if (sp > 7) sp = 7;
        return {m_phase == P_START,
                (m_phase == P_LOAD) || (m_phase == P_SHOW_ON && m_prev == P_SHOW_OFF),
                m_phase == P_LOAD,
                m_phase == P_CLEAR,
                m_phase == P_SHOW_ON,
                6'(m_idx), 3'(sp), 6'(m_round),
                m_phase == P_WIN,
                m_phase == P_LOSE};
    endfunction

    task automatic check_model(input string tag);
        logic [21:0] obs, exp;
        obs = {bus.start, bus.load_colour, bus.load_speed, bus.rst_seedgen, bus.flash_clk,
               bus.check_round, bus.speed, bus.round, bus.win, bus.lose};
        exp = model_vec();
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic tick(input bit go, input bit press, input bit res, input bit pls);
        bus.btn_go    = go;
        bus.btn_press = press;
        bus.result    = res;
        bus.pulse     = pls;
        @(posedge clk);
        model_step(go, press, res, pls);
        #1;
        check_model("cycle");
        bus.btn_go    = 1'b0;
        bus.btn_press = 1'b0;
        bus.result    = 1'b0;
        bus.pulse     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0);
    endtask

    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_reset");
        #2 rst_n = 1'b1;
    endtask

    // Entered in SHOW_ON with index 0; leaves in INPUT.
    task automatic play_show(input int r);
        for (int i = 0; i <= r; i++) begin
            chk("flash_on", 32'(bus.flash_clk), 32'd1);
            chk("flash_idx", 32'(bus.check_round), 32'(i));
            idle(1);
            tick(0, 0, 0, 1);
            chk("flash_off", 32'(bus.flash_clk), 32'd0);
            idle(1);
            tick(0, 0, 0, 1);
        end
        chk("input_idx0", 32'(bus.check_round), 32'd0);
    endtask

    task automatic play_input(input int r, input int bad_at, input bit with_pulse);
        for (int i = 0; i <= r; i++) begin
            idle(1);
            tick(0, 1, (i != bad_at), with_pulse);
            if (i == bad_at) break;
        end
    endtask

    initial begin
        bus.btn_go = 1'b0; bus.btn_press = 1'b0; bus.result = 1'b0; bus.pulse = 1'b0;
        model_reset();
        #12;
        check_model("reset_hold");
        chk("reset_seedgen", 32'(bus.rst_seedgen), 32'd1);
        chk("reset_speed", 32'(bus.speed), 32'(INIT_SPEED));
        chk("reset_start", 32'(bus.start), 32'd0);
        rst_n = 1'b1;
        tick(0, 0, 0, 0);
        chk("release_seedgen", 32'(bus.rst_seedgen), 32'd0);
        tick(0, 1, 1, 1);
        idle(2);

        // full game to WIN, speed 6,6,7,7,7,7
        tick(1, 0, 0, 0);
        chk("start_strobe", 32'(bus.start), 32'd1);
        tick(0, 0, 0, 0);
        for (int r = 0; r < MAX_ROUND; r++) begin
            chk("load_speed", 32'(bus.load_speed), 32'd1);
            chk("load_colour", 32'(bus.load_colour), 32'd1);
            chk("round_speed", 32'(bus.speed), (r < 2) ? 32'd6 : 32'd7);
            chk("round_val", 32'(bus.round), 32'(r));
            tick(0, 0, 0, 0);
            play_show(r);
            play_input(r, -1, 0);
        end
        chk("win", 32'(bus.win), 32'd1);
        tick(0, 1, 1, 1);
        tick(0, 0, 0, 1);
        chk("win_hold", 32'(bus.win), 32'd1);
        chk("win_round", 32'(bus.round), 32'd5);
        tick(1, 0, 0, 0);
        chk("restart_seedgen", 32'(bus.rst_seedgen), 32'd1);
        tick(0, 0, 0, 0);
        chk("restart_idle", 32'(bus.rst_seedgen), 32'd0);

        // wrong entry at index 1 of round 1
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        play_show(0);
        play_input(0, -1, 1);
        chk("round1", 32'(bus.round), 32'd1);
        tick(0, 0, 0, 0);
        play_show(1);
        play_input(1, 1, 0);
        chk("lose", 32'(bus.lose), 32'd1);
        idle(3);
        chk("lose_hold", 32'(bus.lose), 32'd1);
        tick(1, 0, 0, 0);
        chk("lose_clear", 32'(bus.rst_seedgen), 32'd1);
        tick(0, 0, 0, 0);

        // reset in the middle of SHOW_ON
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        idle(1);
        async_reset();
        chk("mid_reset_flash", 32'(bus.flash_clk), 32'd0);
        chk("mid_reset_seedgen", 32'(bus.rst_seedgen), 32'd1);
        idle(6);
        chk("no_restart", 32'(bus.start), 32'd0);

        // random strobes
        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(0, 999) == 0) begin
                async_reset();
            end else begin
                tick($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
